sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one single-port SRAM_wrapper instance (14-bit word address, 32-bit data, 4-bit active-low byte write enables) between two requesters.
- Typical requesters are the CPU data port (m0) and a loader/DMA engine (m1).
- Arbitration is weighted round-robin with bounded hold. Read data is returned with the SRAM's one-cycle latency, and a response-tracking register routes it to the correct master.
- Sits in top between the requesters and the DM SRAM_wrapper.

Parameters:
- ADDR_W, 14, SRAM word address width
- DATA_W, 32, data width
- HOLD_MAX, 4, max consecutive grants to the current owner while the other master is requesting (legal range >= 1)

Ports:
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  synchronous active-high reset
- m0_req  input  1  master 0 access request, held until granted
- m0_gnt  output  1  master 0 access accepted this cycle
- m0_addr  input  ADDR_W  master 0 word address
- m0_web  input  4  master 0 byte write enables, active low; 4'b1111 = read
- m0_wdata  input  DATA_W  master 0 write data
- m0_rvalid  output  1  master 0 read data valid
- m0_rdata  output  DATA_W  master 0 read data
- m1_req / m1_gnt / m1_addr / m1_web / m1_wdata / m1_rvalid / m1_rdata: same as m0, for master 1
- sram_cs  output  1  SRAM chip select
- sram_oe  output  1  SRAM output enable
- sram_web  output  4  SRAM byte write enables, active low
- sram_a  output  ADDR_W  SRAM address
- sram_di  output  DATA_W  SRAM write data
- sram_do  input  DATA_W  SRAM read data, valid one cycle after address is sampled

Behaviour:
- Reset and default values:
  - While rst=1: m0_gnt=m1_gnt=0, sram_cs=0, sram_web=4'hF, sram_a=0, sram_di=0, m0_rvalid=m1_rvalid=0.
  - Internal state resets to owner=0, cnt=0, pend_valid=0.
- Internal state:
  - owner: 1 bit, last granted master.
  - cnt: saturating at HOLD_MAX, width clog2(HOLD_MAX+1); counts consecutive grants to owner.
  - pend_valid, pend_id: read-response tracking register.
- Grant logic (combinational, same cycle as req; masked to 0 during rst):
  - Only one master requesting: that master is granted.
  - Both requesting: owner is granted if cnt < HOLD_MAX, else the other master.
  - No master requesting: no grant.
  - At most one gnt is high per cycle. The handshake completes in any cycle where req & gnt.
- State update (rising edge, rst=0):
  - Grant to owner: cnt <= min(cnt+1, HOLD_MAX).
  - Grant to the other master: owner <= granted master, cnt <= 1.
  - No grant: cnt <= 0, owner unchanged.
- SRAM drive (combinational):
  - When a master is granted: sram_cs=1; sram_a, sram_web and sram_di come from that master.
  - When no master is granted: sram_cs=0, sram_web=4'hF, sram_a and sram_di hold 0.
  - sram_oe is tied to 1.
- Writes:
  - Committed by the SRAM at the rising edge ending the grant cycle.
  - Partial byte writes are passed through unchanged.
  - No rvalid is produced for a write.
- Reads (web==4'hF):
  - Granted at cycle N: pend_valid <= 1 and pend_id <= granted master.
  - In cycle N+1, mX_rvalid = pend_valid & (pend_id==X).
  - Reads may be accepted every cycle, and back-to-back reads from alternating masters are allowed.
- Read data routing:
  - m0_rdata = m1_rdata = sram_do, unqualified.
  - Consumers sample read data only when their rvalid is high.
- Reset mid-operation: a pending read is dropped (no rvalid), and arbitration restarts with m0 favoured.
- Simultaneous read-response and new grant in the same cycle is legal, since they are independent pipeline stages.
- There is no combinational path from sram_do to any gnt.

Test Plan:
1. Reset: assert rst 3 cycles with m0_req=m1_req=1 -> gnt both 0, sram_cs=0, sram_web=4'hF, rvalid both 0. First cycle after release -> m0_gnt=1.
2. Write/read and byte-mask on m0:
   - Write 0xDEADBEEF to 0x0010 (web=0000), then read 0x0010 -> m0_rvalid=1 exactly one cycle after the read grant, with m0_rdata=0xDEADBEEF.
   - Write 0x000000AA with web=4'b1110, then read -> 0xDEADBEAA.
   - m1_rvalid stays 0 throughout.
3. Contention, HOLD_MAX=4: both masters hold req=1 for 16 cycles -> grant sequence m0×4, m1×4, m0×4, m1×4. With HOLD_MAX=1 -> strict alternation.
4. Hand-over: m0 granted 2 cycles, then only m1 requests -> m1_gnt=1 the same cycle with no bubble. m0 re-requests while m1 continues -> m1 keeps the grant until 4 consecutive grants, then m0 is granted.
5. Interleaved reads: preload addr 0x0001=0x11111111 and 0x0002=0x22222222. m0 reads 0x0001 and m1 reads 0x0002 in consecutive grant cycles -> m0_rvalid with 0x11111111, then m1_rvalid with 0x22222222 next cycle; never both rvalid high in one cycle.
6. Reset mid-read: m1 read granted at cycle N, rst=1 in cycle N+1 -> m1_rvalid=0 in cycle N+1. After release with both requesting -> m0 granted first.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Request/response bundle for one master port of sram_port_arbiter.
// The master drives the request fields; the arbiter returns grant and read data.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              req;
  logic              gnt;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        web;
  logic [DATA_W-1:0] wdata;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, addr, web, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, web, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-master arbiter for a single-port SRAM: weighted round-robin with bounded
// hold, plus a one-entry tracker that steers 1-cycle read data to its requester.
module sram_port_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  sram_port_arbiter_if.slave m0,
  sram_port_arbiter_if.slave m1,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic [3:0]        sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_di,
  input  logic [DATA_W-1:0] sram_do
);

  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);

  typedef enum logic {OWN_M0 = 1'b0, OWN_M1 = 1'b1} owner_e;

  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_valid_q, pend_valid_d;
  owner_e           pend_id_q, pend_id_d;

  logic   gnt0, gnt1, gnt_any;
  owner_e gnt_id;

  // Grant decision: the owner keeps the port under contention until it has
  // used HOLD_MAX consecutive grants.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (m0.req && m1.req) begin
        if (cnt_q < CNT_MAX) gnt0 = (owner_q == OWN_M0);
        else                 gnt0 = (owner_q == OWN_M1);
        gnt1 = !gnt0;
      end else begin
        gnt0 = m0.req;
        gnt1 = m1.req;
      end
    end
  end

  assign gnt_any = gnt0 | gnt1;
  assign gnt_id  = gnt1 ? OWN_M1 : OWN_M0;
  assign m0.gnt  = gnt0;
  assign m1.gnt  = gnt1;

  // SRAM drive: idle bus parks at cs=0, web=F, address/data zero.
  always_comb begin
    sram_cs  = gnt_any;
    sram_web = 4'hF;
    sram_a   = '0;
    sram_di  = '0;
    if (gnt0) begin
      sram_web = m0.web;
      sram_a   = m0.addr;
      sram_di  = m0.wdata;
    end else if (gnt1) begin
      sram_web = m1.web;
      sram_a   = m1.addr;
      sram_di  = m1.wdata;
    end
  end

  assign sram_oe = 1'b1;

  // NOTE: every variable gets a default before any branch, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    pend_valid_d = gnt_any && (sram_web == 4'hF);
    pend_id_d    = gnt_any ? gnt_id : pend_id_q;
    if (!gnt_any) begin
      cnt_d = '0;
    end else if (gnt_id == owner_q) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else begin
      owner_d = gnt_id;
      cnt_d   = CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWN_M0;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      // NOTE: pend_id is only meaningful under pend_valid, but it is reset too
      // so the response path never starts from an unknown master id.
      pend_id_q    <= OWN_M0;
    end else begin
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_id_q    <= pend_id_d;
    end
  end

  // A response still in flight when reset arrives is dropped immediately.
  assign m0.rvalid = !rst && pend_valid_q && (pend_id_q == OWN_M0);
  assign m1.rvalid = !rst && pend_valid_q && (pend_id_q == OWN_M1);
  assign m0.rdata  = sram_do;
  assign m1.rdata  = sram_do;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: HOLD_MAX=4 instance on a behavioural SRAM plus a
// HOLD_MAX=1 instance shadowing the same requests for the alternation check.
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  sram_port_arbiter_if #(.ADDR_W(14), .DATA_W(32)) a0 ();
  sram_port_arbiter_if #(.ADDR_W(14), .DATA_W(32)) a1 ();
  sram_port_arbiter_if #(.ADDR_W(14), .DATA_W(32)) b0 ();
  sram_port_arbiter_if #(.ADDR_W(14), .DATA_W(32)) b1 ();

  logic        sram_cs, sram_oe;
  logic [3:0]  sram_web;
  logic [13:0] sram_a;
  logic [31:0] sram_di, sram_do;

  logic        h_cs, h_oe;
  logic [3:0]  h_web;
  logic [13:0] h_a;
  logic [31:0] h_di;
  logic [31:0] h_do = 32'h0;

  sram_port_arbiter #(.ADDR_W(14), .DATA_W(32), .HOLD_MAX(4)) dut (
    .clk(clk), .rst(rst), .m0(a0), .m1(a1),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web),
    .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
  );

  sram_port_arbiter #(.ADDR_W(14), .DATA_W(32), .HOLD_MAX(1)) dut_h1 (
    .clk(clk), .rst(rst), .m0(b0), .m1(b1),
    .sram_cs(h_cs), .sram_oe(h_oe), .sram_web(h_web),
    .sram_a(h_a), .sram_di(h_di), .sram_do(h_do)
  );

  assign b0.req = a0.req;  assign b0.addr = a0.addr;
  assign b0.web = a0.web;  assign b0.wdata = a0.wdata;
  assign b1.req = a1.req;  assign b1.addr = a1.addr;
  assign b1.web = a1.web;  assign b1.wdata = a1.wdata;

  // Behavioural single-port SRAM with active-low byte enables, 1-cycle read.
  logic [31:0] mem [0:16383];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_web == 4'hF) sram_do <= mem[sram_a];
      else
        for (int i = 0; i < 4; i++)
          if (!sram_web[i]) mem[sram_a][8*i +: 8] <= sram_di[8*i +: 8];
    end
  end

  // Read-response scoreboard: tasks push {id,data} when a read is driven.
  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } rsp_t;
  rsp_t exp_q[$];

  logic rd_prev0 = 1'b0, rd_prev1 = 1'b0;
  logic exp_rv0, exp_rv1;
  rsp_t rsp;
  logic [31:0] got_data;

  always @(negedge clk) begin
    exp_rv0 = rd_prev0 && !rst;
    exp_rv1 = rd_prev1 && !rst;
    tests_run++;
    if (a0.rvalid !== exp_rv0) begin
      tests_failed++;
      $display("FAIL m0_rvalid t=%0t got=%b want=%b", $time, a0.rvalid, exp_rv0);
    end
    tests_run++;
    if (a1.rvalid !== exp_rv1) begin
      tests_failed++;
      $display("FAIL m1_rvalid t=%0t got=%b want=%b", $time, a1.rvalid, exp_rv1);
    end
    if (a0.rvalid === 1'b1 || a1.rvalid === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL rsp_unexpected t=%0t got rvalid with empty scoreboard, want none", $time);
      end else begin
        rsp = exp_q.pop_front();
        got_data = (a1.rvalid === 1'b1) ? a1.rdata : a0.rdata;
        if ((a1.rvalid !== rsp.id) || (got_data !== rsp.data)) begin
          tests_failed++;
          $display("FAIL rsp_data t=%0t got id=%b data=%h want id=%b data=%h",
                   $time, a1.rvalid, got_data, rsp.id, rsp.data);
        end
      end
    end
    rd_prev0 = (a0.gnt === 1'b1) && (a0.web == 4'hF);
    rd_prev1 = (a1.gnt === 1'b1) && (a1.web == 4'hF);
  end

  task automatic to_drive;
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample;
    @(negedge clk);
  endtask

  task automatic set_m0(input logic r, input logic [13:0] ad, input logic [3:0] w,
                        input logic [31:0] d);
    a0.req = r; a0.addr = ad; a0.web = w; a0.wdata = d;
  endtask

  task automatic set_m1(input logic r, input logic [13:0] ad, input logic [3:0] w,
                        input logic [31:0] d);
    a1.req = r; a1.addr = ad; a1.web = w; a1.wdata = d;
  endtask

  task automatic test_reset;
    set_m0(1'b1, 14'h3FF0, 4'h0, 32'h0);
    set_m1(1'b1, 14'h3FF1, 4'h0, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      to_sample;
      tests_run++;
      if (a0.gnt !== 1'b0 || a1.gnt !== 1'b0 || sram_cs !== 1'b0 ||
          sram_web !== 4'hF || sram_a !== 14'h0 || sram_di !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_outputs got gnt=%b%b cs=%b web=%h a=%h di=%h want 00 0 f 0 0",
                 a1.gnt, a0.gnt, sram_cs, sram_web, sram_a, sram_di);
      end
      if (i < 2) to_drive;
    end
    to_drive;
    rst = 1'b0;
    to_sample;
    tests_run++;
    if (a0.gnt !== 1'b1 || a1.gnt !== 1'b0 || b0.gnt !== 1'b1 || b1.gnt !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release got gnt4=%b%b gnt1=%b%b want 01 01",
               a1.gnt, a0.gnt, b1.gnt, b0.gnt);
    end
    to_drive;
    set_m0(1'b0, 14'h0, 4'hF, 32'h0);
    set_m1(1'b0, 14'h0, 4'hF, 32'h0);
  endtask

  task automatic test_write_read;
    to_drive;
    set_m0(1'b1, 14'h0010, 4'h0, 32'hDEADBEEF);
    to_sample;
    tests_run++;
    if (a0.gnt !== 1'b1 || sram_cs !== 1'b1 || sram_a !== 14'h0010 ||
        sram_web !== 4'h0 || sram_di !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL wr_full got gnt=%b cs=%b a=%h web=%h di=%h want 1 1 0010 0 deadbeef",
               a0.gnt, sram_cs, sram_a, sram_web, sram_di);
    end
    to_drive;
    set_m0(1'b1, 14'h0010, 4'hF, 32'h0);
    exp_q.push_back('{id: 1'b0, data: 32'hDEADBEEF});
    to_sample;
    to_drive;
    set_m0(1'b1, 14'h0010, 4'b1110, 32'h000000AA);
    to_sample;
    tests_run++;
    if (a0.gnt !== 1'b1 || sram_web !== 4'b1110 || sram_di !== 32'h000000AA) begin
      tests_failed++;
      $display("FAIL wr_byte got gnt=%b web=%b di=%h want 1 1110 000000aa",
               a0.gnt, sram_web, sram_di);
    end
    to_drive;
    set_m0(1'b1, 14'h0010, 4'hF, 32'h0);
    exp_q.push_back('{id: 1'b0, data: 32'hDEADBEAA});
    to_sample;
    to_drive;
    set_m0(1'b0, 14'h0, 4'hF, 32'h0);
    to_sample;
    tests_run++;
    if (sram_cs !== 1'b0 || sram_web !== 4'hF || sram_a !== 14'h0) begin
      tests_failed++;
      $display("FAIL idle_bus got cs=%b web=%h a=%h want 0 f 0", sram_cs, sram_web, sram_a);
    end
  endtask

  task automatic test_contention;
    logic e4, e1;
    to_drive;
    set_m0(1'b1, 14'h3F00, 4'h0, 32'h0000_0A0A);
    set_m1(1'b1, 14'h3F01, 4'h0, 32'h0000_0B0B);
    for (int i = 0; i < 16; i++) begin
      to_sample;
      e4 = ((i / 4) % 2) == 0;
      e1 = (i % 2) == 0;
      tests_run++;
      if (a0.gnt !== e4 || a1.gnt !== !e4) begin
        tests_failed++;
        $display("FAIL hold4_seq cycle=%0d got gnt=%b%b want %b%b", i, a1.gnt, a0.gnt, !e4, e4);
      end
      tests_run++;
      if (b0.gnt !== e1 || b1.gnt !== !e1) begin
        tests_failed++;
        $display("FAIL hold1_seq cycle=%0d got gnt=%b%b want %b%b", i, b1.gnt, b0.gnt, !e1, e1);
      end
      to_drive;
    end
    set_m0(1'b0, 14'h0, 4'hF, 32'h0);
    set_m1(1'b0, 14'h0, 4'hF, 32'h0);
  endtask

  task automatic test_handover;
    bit r0_t [7] = '{1, 1, 0, 1, 1, 1, 1};
    bit r1_t [7] = '{0, 0, 1, 1, 1, 1, 1};
    bit g0_t [7] = '{1, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 7; i++) begin
      to_drive;
      set_m0(r0_t[i], 14'h3F10, 4'h0, 32'h1);
      set_m1(r1_t[i], 14'h3F11, 4'h0, 32'h2);
      to_sample;
      tests_run++;
      if (a0.gnt !== g0_t[i] || a1.gnt !== (r1_t[i] && !g0_t[i])) begin
        tests_failed++;
        $display("FAIL handover cycle=%0d got gnt=%b%b want %b%b",
                 i, a1.gnt, a0.gnt, (r1_t[i] && !g0_t[i]), g0_t[i]);
      end
    end
    to_drive;
    set_m0(1'b0, 14'h0, 4'hF, 32'h0);
    set_m1(1'b0, 14'h0, 4'hF, 32'h0);
  endtask

  task automatic test_back_to_back;
    to_drive;
    set_m0(1'b1, 14'h0001, 4'h0, 32'h11111111);
    to_sample;
    to_drive;
    set_m0(1'b0, 14'h0, 4'hF, 32'h0);
    set_m1(1'b1, 14'h0002, 4'h0, 32'h22222222);
    to_sample;
    to_drive;
    set_m1(1'b0, 14'h0, 4'hF, 32'h0);
    set_m0(1'b1, 14'h0001, 4'hF, 32'h0);
    exp_q.push_back('{id: 1'b0, data: 32'h11111111});
    to_sample;
    tests_run++;
    if (a0.gnt !== 1'b1 || sram_a !== 14'h0001) begin
      tests_failed++;
      $display("FAIL b2b_rd0 got gnt=%b a=%h want 1 0001", a0.gnt, sram_a);
    end
    to_drive;
    set_m0(1'b0, 14'h0, 4'hF, 32'h0);
    set_m1(1'b1, 14'h0002, 4'hF, 32'h0);
    exp_q.push_back('{id: 1'b1, data: 32'h22222222});
    to_sample;
    tests_run++;
    if (a1.gnt !== 1'b1 || a0.gnt !== 1'b0 || sram_a !== 14'h0002) begin
      tests_failed++;
      $display("FAIL b2b_rd1 got gnt=%b%b a=%h want 10 0002", a1.gnt, a0.gnt, sram_a);
    end
    to_drive;
    set_m1(1'b0, 14'h0, 4'hF, 32'h0);
    to_sample;
    to_drive;
    to_sample;
  endtask

  task automatic test_reset_mid_read;
    to_drive;
    set_m1(1'b1, 14'h0002, 4'hF, 32'h0);
    to_sample;
    tests_run++;
    if (a1.gnt !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_gnt got m1_gnt=%b want 1", a1.gnt);
    end
    to_drive;
    rst = 1'b1;
    set_m0(1'b1, 14'h3F20, 4'h0, 32'h5);
    set_m1(1'b1, 14'h3F21, 4'h0, 32'h6);
    to_sample;
    tests_run++;
    if (a1.rvalid !== 1'b0 || a0.gnt !== 1'b0 || a1.gnt !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_drop got m1_rvalid=%b gnt=%b%b want 0 00",
               a1.rvalid, a1.gnt, a0.gnt);
    end
    to_drive;
    to_sample;
    to_drive;
    rst = 1'b0;
    to_sample;
    tests_run++;
    if (a0.gnt !== 1'b1 || a1.gnt !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_restart got gnt=%b%b want 01", a1.gnt, a0.gnt);
    end
    to_drive;
    set_m0(1'b0, 14'h0, 4'hF, 32'h0);
    set_m1(1'b0, 14'h0, 4'hF, 32'h0);
    to_sample;
    to_drive;
    to_sample;
  endtask

  initial begin
    set_m0(1'b0, 14'h0, 4'hF, 32'h0);
    set_m1(1'b0, 14'h0, 4'hF, 32'h0);
    test_reset;
    test_write_read;
    test_contention;
    test_handover;
    test_back_to_back;
    test_reset_mid_read;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rsp_outstanding got %0d responses missing, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
